// File: rtl/ln_p_calculator.sv
// ln_p_calculator
//   Inverts the quadratic exponent approximation
//     f(p) = floor((359*p^2 + 970*p + 1000) / 1000)
//   returning the largest unsigned p with f(p) <= y. The search is MSB-first
//   and resolves one result bit per clock.
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   in_valid   y is valid
//   in_ready   block can accept y (state decode only)
//   y          value to invert (unsigned, BITWIDTH bits)
//   out_valid  p / underflow are valid (registered)
//   out_ready  consumer accepts the result
//   p          largest p with f(p) <= y (registered)
//   underflow  no p satisfies f(p) <= y, only when y == 0 (registered)
module ln_p_calculator #(
  parameter int BITWIDTH = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [BITWIDTH-1:0] y,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [BITWIDTH-1:0] p,
  output logic                underflow
);

  localparam int NW = 2 * BITWIDTH + 10;  // width of N(c)
  localparam int BW = BITWIDTH + 10;      // width of the bound 1000*y+999
  localparam int IW = (BITWIDTH > 1) ? $clog2(BITWIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [BW-1:0]         r_bound;
  logic                  r_uf_work;
  logic [BITWIDTH-1:0]   r_result;
  logic [IW-1:0]         r_idx;
  logic [BITWIDTH-1:0]   r_p;
  logic                  r_underflow;

  logic [BITWIDTH-1:0]   w_cand;
  logic [NW-1:0]         w_c_ext;
  logic [NW-1:0]         w_n;
  logic                  w_fit;

  // Trial candidate and its scaled exponent value. floor(N/1000) <= y is
  // equivalent to N <= 1000*y + 999, so no divider is needed.
  always_comb begin
    w_cand  = r_result | (BITWIDTH'(1) << r_idx);
    w_c_ext = NW'(w_cand);
    w_n     = NW'(359) * w_c_ext * w_c_ext + NW'(970) * w_c_ext + NW'(1000);
    w_fit   = (w_n <= NW'(r_bound));
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (in_valid)      w_state_nxt = CALC;
      CALC:    if (r_idx == '0)   w_state_nxt = DONE;
      DONE:    if (out_ready)     w_state_nxt = IDLE;
      default:                    w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_bound     <= '0;
      r_uf_work   <= 1'b0;
      r_result    <= '0;
      r_idx       <= '0;
      r_p         <= '0;
      r_underflow <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_bound   <= BW'(1000) * BW'(y) + BW'(999);
            r_uf_work <= (y == '0);
            r_result  <= '0;
            r_idx     <= IW'(BITWIDTH - 1);
          end
        end
        CALC: begin
          if (w_fit) r_result <= w_cand;
          if (r_idx != '0) begin
            r_idx <= r_idx - 1'b1;
          end else begin
            // Last bit: publish the final value directly so p is valid
            // together with out_valid on entry to DONE.
            r_p         <= w_fit ? w_cand : r_result;
            r_underflow <= r_uf_work;
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (r_state == IDLE);
  assign out_valid = (r_state == DONE);
  assign p         = r_p;
  assign underflow = r_underflow;

endmodule
